// File: rtl/obstacle_bank_if.sv
// Bus bundle for obstacle_bank.
//   master: movers/video side; drives positions, frame_tick and the draw pixel.
//   slave : the obstacle bank; returns blocking flags, hit pulses, alive mask, draw lookup.
// frame_tick   one-cycle pulse per video frame
// obst_x/y     packed 10-bit top-left per obstacle, index i at [10i+9:10i]
// Tank*/p*_Bull* 10-bit centre coordinates
// DrawX/DrawY  current VGA pixel
// is_obst*     tank overlaps any alive obstacle (combinational)
// hitobj1/2    registered one-cycle bullet-absorb pulses
// obst_alive   per-obstacle alive flag
// draw_*       priority-resolved pixel lookup (combinational)
interface obstacle_bank_if #(
  parameter int unsigned NUM_OBST = 4
);
  logic                  frame_tick;
  logic [10*NUM_OBST-1:0] obst_x;
  logic [10*NUM_OBST-1:0] obst_y;
  logic [9:0]            Tank1X, Tank1Y, Tank2X, Tank2Y;
  logic [9:0]            p1_BullX, p1_BullY, p2_BullX, p2_BullY;
  logic [9:0]            DrawX, DrawY;
  logic                  is_obst, is_obst_2;
  logic                  hitobj1, hitobj2;
  logic [NUM_OBST-1:0]   obst_alive;
  logic                  draw_hit;
  logic [3:0]            draw_idx;
  logic [19:0]           draw_ofs;
  logic [3:0]            draw_health;

  modport master (
    output frame_tick, obst_x, obst_y, Tank1X, Tank1Y, Tank2X, Tank2Y,
           p1_BullX, p1_BullY, p2_BullX, p2_BullY, DrawX, DrawY,
    input  is_obst, is_obst_2, hitobj1, hitobj2, obst_alive,
           draw_hit, draw_idx, draw_ofs, draw_health
  );

  modport slave (
    input  frame_tick, obst_x, obst_y, Tank1X, Tank1Y, Tank2X, Tank2Y,
           p1_BullX, p1_BullY, p2_BullX, p2_BullY, DrawX, DrawY,
    output is_obst, is_obst_2, hitobj1, hitobj2, obst_alive,
           draw_hit, draw_idx, draw_ofs, draw_health
  );
endinterface

// File: rtl/obstacle_bank.sv
// Bank of NUM_OBST destructible rectangular obstacles for the tank arena.
// Ports: Clk, Reset_h (synchronous, active high), bus (obstacle_bank_if.slave).
// Each obstacle counts edge-detected bullet hits, dies at MAXHITS and
// respawns after RESPAWN_FRAMES frame ticks (0 = never). Tank blocking and
// the draw lookup are combinational; hit pulses are registered.
module obstacle_bank #(
  parameter int unsigned NUM_OBST       = 4,
  parameter int unsigned OBST_W         = 8,
  parameter int unsigned OBST_H         = 8,
  parameter int unsigned MAXHITS        = 10,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned BULL_HALF      = 1,
  parameter int unsigned TANK_SIZE      = 8
) (
  input  logic            Clk,
  input  logic            Reset_h,
  obstacle_bank_if.slave  bus
);

  localparam int unsigned CNT_W = (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);
  localparam logic [10:0] W11   = 11'(OBST_W);
  localparam logic [10:0] H11   = 11'(OBST_H);
  localparam logic [10:0] BH11  = 11'(BULL_HALF);
  localparam logic [10:0] TS11  = 11'(TANK_SIZE);

  typedef enum logic {ALIVE = 1'b0, DEAD = 1'b1} obst_state_t;

  obst_state_t      state_q [NUM_OBST];
  obst_state_t      state_d [NUM_OBST];
  logic [3:0]       hits_q  [NUM_OBST];
  logic [3:0]       hits_d  [NUM_OBST];
  logic [CNT_W-1:0] resp_q  [NUM_OBST];
  logic [CNT_W-1:0] resp_d  [NUM_OBST];
  logic [NUM_OBST-1:0] ovl1_q, ovl1_d, ovl2_q, ovl2_d;
  logic [NUM_OBST-1:0] alive, ovl1, ovl2, tovl1, tovl2, new1, new2;
  logic             hit1_q, hit2_q;

  function automatic logic [10:0] ext(input logic [9:0] v);
    return {1'b0, v};
  endfunction

  // Bullet box (half-open on the far side) against obstacle rectangle.
  function automatic logic bull_ovl(input logic [10:0] bx, by, ox, oy);
    return (bx + BH11 >= ox) && (bx < ox + W11 + BH11) &&
           (by + BH11 >= oy) && (by < oy + H11 + BH11);
  endfunction

  // Tank box, inclusive on both sides.
  function automatic logic tank_ovl(input logic [10:0] tx, ty, ox, oy);
    return (tx + TS11 >= ox) && (tx <= ox + W11 + TS11) &&
           (ty + TS11 >= oy) && (ty <= oy + H11 + TS11);
  endfunction

  // Saturating hit accumulation; two simultaneous hits add two.
  function automatic logic [3:0] add_hits(input logic [3:0] h, input logic a, input logic b);
    logic [4:0] s;
    s = 5'(h) + 5'(a) + 5'(b);
    return (s >= 5'(MAXHITS)) ? 4'(MAXHITS) : s[3:0];
  endfunction

  // Per-obstacle overlap terms, all gated by alive.
  always_comb begin
    alive = '0;
    ovl1  = '0;
    ovl2  = '0;
    tovl1 = '0;
    tovl2 = '0;
    for (int i = 0; i < NUM_OBST; i++) begin
      alive[i] = (state_q[i] == ALIVE);
      ovl1[i]  = alive[i] && bull_ovl(ext(bus.p1_BullX), ext(bus.p1_BullY),
                                       ext(bus.obst_x[10*i +: 10]), ext(bus.obst_y[10*i +: 10]));
      ovl2[i]  = alive[i] && bull_ovl(ext(bus.p2_BullX), ext(bus.p2_BullY),
                                       ext(bus.obst_x[10*i +: 10]), ext(bus.obst_y[10*i +: 10]));
      tovl1[i] = alive[i] && tank_ovl(ext(bus.Tank1X), ext(bus.Tank1Y),
                                       ext(bus.obst_x[10*i +: 10]), ext(bus.obst_y[10*i +: 10]));
      tovl2[i] = alive[i] && tank_ovl(ext(bus.Tank2X), ext(bus.Tank2Y),
                                       ext(bus.obst_x[10*i +: 10]), ext(bus.obst_y[10*i +: 10]));
    end
  end

  assign new1           = ovl1 & ~ovl1_q;
  assign new2           = ovl2 & ~ovl2_q;
  assign bus.is_obst    = |tovl1;
  assign bus.is_obst_2  = |tovl2;
  assign bus.obst_alive = alive;
  assign bus.hitobj1    = hit1_q;
  assign bus.hitobj2    = hit2_q;

  // Next-state for every obstacle FSM.
  always_comb begin
    ovl1_d = ovl1;
    ovl2_d = ovl2;
    for (int i = 0; i < NUM_OBST; i++) begin
      state_d[i] = state_q[i];
      hits_d[i]  = hits_q[i];
      resp_d[i]  = resp_q[i];
      case (state_q[i])
        ALIVE: begin
          hits_d[i] = add_hits(hits_q[i], new1[i], new2[i]);
          if (hits_d[i] == 4'(MAXHITS)) begin
            state_d[i] = DEAD;
            resp_d[i]  = CNT_W'(RESPAWN_FRAMES);
            ovl1_d[i]  = 1'b0;
            ovl2_d[i]  = 1'b0;
          end
        end
        DEAD: begin
          if (bus.frame_tick && (RESPAWN_FRAMES != 0)) begin
            if (resp_q[i] == CNT_W'(1)) begin
              state_d[i] = ALIVE;
              hits_d[i]  = '0;
              resp_d[i]  = '0;
            end else begin
              resp_d[i] = resp_q[i] - CNT_W'(1);
            end
          end
        end
        default: state_d[i] = ALIVE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      for (int i = 0; i < NUM_OBST; i++) begin
        state_q[i] <= ALIVE;
        hits_q[i]  <= '0;
        resp_q[i]  <= '0;
      end
      ovl1_q <= '0;
      ovl2_q <= '0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OBST; i++) begin
        state_q[i] <= state_d[i];
        hits_q[i]  <= hits_d[i];
        resp_q[i]  <= resp_d[i];
      end
      ovl1_q <= ovl1_d;
      ovl2_q <= ovl2_d;
      hit1_q <= |new1;
      hit2_q <= |new2;
    end
  end

  // Draw lookup: scan from the top index down so the lowest index wins.
  always_comb begin
    bus.draw_hit    = 1'b0;
    bus.draw_idx    = '0;
    bus.draw_ofs    = '0;
    bus.draw_health = '0;
    for (int i = NUM_OBST - 1; i >= 0; i--) begin
      if (alive[i] &&
          ext(bus.DrawX) >= ext(bus.obst_x[10*i +: 10]) &&
          ext(bus.DrawX) <  ext(bus.obst_x[10*i +: 10]) + W11 &&
          ext(bus.DrawY) >= ext(bus.obst_y[10*i +: 10]) &&
          ext(bus.DrawY) <  ext(bus.obst_y[10*i +: 10]) + H11) begin
        bus.draw_hit    = 1'b1;
        bus.draw_idx    = 4'(i);
        bus.draw_ofs    = {bus.DrawX - bus.obst_x[10*i +: 10], bus.DrawY - bus.obst_y[10*i +: 10]};
        bus.draw_health = 4'(MAXHITS) - hits_q[i];
      end
    end
  end

endmodule

// File: tb/tb_obstacle_bank.sv
// Directed testbench for obstacle_bank (2 obstacles, MAXHITS=10, RESPAWN_FRAMES=3).
module tb_obstacle_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  obstacle_bank_if #(.NUM_OBST(2)) bus ();

  obstacle_bank #(
    .NUM_OBST(2), .OBST_W(8), .OBST_H(8), .MAXHITS(10),
    .RESPAWN_FRAMES(3), .BULL_HALF(1), .TANK_SIZE(8)
  ) dut (
    .Clk(clk),
    .Reset_h(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obst(input int i, input int x, input int y);
    bus.obst_x[10*i +: 10] = 10'(x);
    bus.obst_y[10*i +: 10] = 10'(y);
  endtask

  task automatic bull1(input int x, input int y);
    bus.p1_BullX = 10'(x);
    bus.p1_BullY = 10'(y);
  endtask

  task automatic bull2(input int x, input int y);
    bus.p2_BullX = 10'(x);
    bus.p2_BullY = 10'(y);
  endtask

  task automatic draw(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.obst_x = '0;
    bus.obst_y = '0;
    set_obst(0, 100, 100);
    set_obst(1, 500, 500);
    bus.Tank1X = '0; bus.Tank1Y = '0;
    bus.Tank2X = '0; bus.Tank2Y = '0;
    bull1(0, 0);
    bull2(0, 0);
    bus.DrawX = '0; bus.DrawY = '0;

    // Reset state
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_alive", 32'(bus.obst_alive), 32'd3);
    chk("rst_hit1", 32'(bus.hitobj1), 32'd0);
    chk("rst_hit2", 32'(bus.hitobj2), 32'd0);
    draw(101, 101);
    chk("rst_health", 32'(bus.draw_health), 32'd10);

    // Resting bullet counts once
    bull1(104, 104);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      pulses += int'(bus.hitobj1);
    end
    chk("rest_pulses", 32'(pulses), 32'd1);
    draw(101, 101);
    chk("rest_health", 32'(bus.draw_health), 32'd9);

    // Nine more toggles destroy obstacle 0 (hits 1 -> 10)
    bull1(0, 0);
    step();
    for (int k = 0; k < 9; k++) begin
      bull1(104, 104);
      step();
      chk("tog_pulse", 32'(bus.hitobj1), 32'd1);
      chk("tog_alive", 32'(bus.obst_alive[0]), (k == 8) ? 32'd0 : 32'd1);
      bull1(0, 0);
      step();
      chk("tog_low", 32'(bus.hitobj1), 32'd0);
    end
    draw(101, 101);
    chk("dead_draw_hit", 32'(bus.draw_hit), 32'd0);
    chk("dead_draw_ofs", 32'(bus.draw_ofs), 32'd0);
    chk("dead_draw_health", 32'(bus.draw_health), 32'd0);
    bus.Tank1X = 10'd96; bus.Tank1Y = 10'd96;
    #1;
    chk("dead_tank", 32'(bus.is_obst), 32'd0);

    // Respawn after three ticks with bullet and tank already overlapping
    bull1(104, 104);
    tick();
    tick();
    chk("resp_t2_alive", 32'(bus.obst_alive[0]), 32'd0);
    tick();
    chk("resp_t3_alive", 32'(bus.obst_alive[0]), 32'd1);
    chk("resp_t3_hit", 32'(bus.hitobj1), 32'd0);
    chk("resp_tank", 32'(bus.is_obst), 32'd1);
    draw(101, 101);
    chk("resp_health", 32'(bus.draw_health), 32'd10);
    step();
    chk("resp_pulse", 32'(bus.hitobj1), 32'd1);
    step();
    chk("resp_pulse_end", 32'(bus.hitobj1), 32'd0);
    draw(101, 101);
    chk("resp_health2", 32'(bus.draw_health), 32'd9);

    // Overlapping obstacles: lowest index wins
    bus.Tank1X = '0; bus.Tank1Y = '0;
    bull1(0, 0);
    set_obst(1, 104, 104);
    step();
    draw(106, 106);
    chk("prio_idx0", 32'(bus.draw_idx), 32'd0);
    chk("prio_ofs0", 32'(bus.draw_ofs), {12'd0, 10'd6, 10'd6});

    // Simultaneous p1/p2 hits on obstacle 0 only (hits 1 -> 3)
    bull1(101, 101);
    bull2(100, 100);
    step();
    chk("dual_h1", 32'(bus.hitobj1), 32'd1);
    chk("dual_h2", 32'(bus.hitobj2), 32'd1);
    draw(101, 101);
    chk("dual_health", 32'(bus.draw_health), 32'd7);
    bull1(0, 0);
    bull2(0, 0);
    step();
    for (int k = 0; k < 6; k++) begin
      bull1(101, 101);
      step();
      bull1(0, 0);
      step();
    end
    draw(101, 101);
    chk("pre_sat_health", 32'(bus.draw_health), 32'd1);
    bull1(101, 101);
    bull2(100, 100);
    step();
    chk("sat_h1", 32'(bus.hitobj1), 32'd1);
    chk("sat_h2", 32'(bus.hitobj2), 32'd1);
    chk("sat_alive", 32'(bus.obst_alive), 32'd2);
    bull1(0, 0);
    bull2(0, 0);
    step();
    draw(106, 106);
    chk("prio_idx1", 32'(bus.draw_idx), 32'd1);
    chk("prio_ofs1", 32'(bus.draw_ofs), {12'd0, 10'd2, 10'd2});
    chk("prio_health1", 32'(bus.draw_health), 32'd10);

    // Tank edges against obstacle 1 moved to (100,100)
    set_obst(1, 100, 100);
    bus.Tank1X = 10'd92;  bus.Tank1Y = 10'd100; #1;
    chk("tank_left_in", 32'(bus.is_obst), 32'd1);
    bus.Tank1X = 10'd91;  #1;
    chk("tank_left_out", 32'(bus.is_obst), 32'd0);
    bus.Tank1X = 10'd116; #1;
    chk("tank_right_in", 32'(bus.is_obst), 32'd1);
    bus.Tank1X = 10'd117; #1;
    chk("tank_right_out", 32'(bus.is_obst), 32'd0);
    set_obst(1, 1015, 100);
    bus.Tank2X = 10'd1023; bus.Tank2Y = 10'd100;
    bus.Tank1X = 10'd0;    bus.Tank1Y = 10'd100;
    #1;
    chk("tank2_nowrap", 32'(bus.is_obst_2), 32'd1);
    chk("tank1_nowrap", 32'(bus.is_obst), 32'd0);

    // Reset in the middle of obstacle 0's respawn
    tick();
    chk("mid_resp_dead", 32'(bus.obst_alive[0]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst2_alive", 32'(bus.obst_alive), 32'd3);
    draw(101, 101);
    chk("rst2_health", 32'(bus.draw_health), 32'd10);
    chk("rst2_idx", 32'(bus.draw_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_bank.md
Name: obstacle_bank

Overview:
- Parametrised bank of NUM_OBST destructible rectangular obstacles for the tank arena.
- Per obstacle: placement, edge-detected bullet hit accounting with health, destruction, and a frame-timed respawn.
- Outputs: tank-blocking flags, one-cycle bullet-absorb pulses, and a priority-resolved pixel lookup for the colour mapper.
- Sits between the tank/bullet movers and the VGA colour mapper; one instance replaces a row of single-obstacle instances.

Parameters:
NUM_OBST, 4, number of obstacles (1..16)
OBST_W, 8, obstacle width in pixels
OBST_H, 8, obstacle height in pixels
MAXHITS, 10, hits that destroy an obstacle (1..15)
RESPAWN_FRAMES, 120, frame_tick count before a destroyed obstacle respawns; 0 = never respawn
BULL_HALF, 1, bullet half-size in pixels
TANK_SIZE, 8, tank half-width in pixels

Ports:
Clk  in  1  system clock
Reset_h  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
obst_x  in  10*NUM_OBST  packed top-left X per obstacle; index i at [10i+9:10i]
obst_y  in  10*NUM_OBST  packed top-left Y per obstacle; same packing
Tank1X, Tank1Y, Tank2X, Tank2Y  in  10 each  tank centre coordinates
p1_BullX, p1_BullY, p2_BullX, p2_BullY  in  10 each  bullet centre coordinates
DrawX, DrawY  in  10 each  current VGA pixel
is_obst  out  1  tank 1 overlaps any alive obstacle
is_obst_2  out  1  tank 2 overlaps any alive obstacle
hitobj1  out  1  one-cycle pulse: p1 bullet newly struck an alive obstacle
hitobj2  out  1  one-cycle pulse: p2 bullet newly struck an alive obstacle
obst_alive  out  NUM_OBST  per-obstacle alive flag
draw_hit  out  1  DrawX/DrawY inside an alive obstacle
draw_idx  out  4  index of the drawn obstacle
draw_ofs  out  20  {DrawX-x, DrawY-y} of the drawn obstacle, 10 bits each
draw_health  out  4  remaining hits (MAXHITS-hits) of the drawn obstacle

Behaviour:
- Reset:
  - All obstacles go to ALIVE with hits=0, respawn counter=0, overlap history cleared.
  - hitobj1 and hitobj2 are 0.
  - obst_alive is all ones.
- Arithmetic: all comparisons in 11 bits (zero-extended), so x+OBST_W+TANK_SIZE never wraps.
- Bullet overlap for obstacle i, bullet b:
  - Condition: bx+BULL_HALF >= x, bx < x+OBST_W+BULL_HALF, by+BULL_HALF >= y, by < y+OBST_H+BULL_HALF.
  - Gated by alive[i].
- Tank overlap for obstacle i: tx+TANK_SIZE >= x, tx <= x+OBST_W+TANK_SIZE, likewise in Y (inclusive). Gated by alive[i].
- is_obst and is_obst_2 are combinational ORs over all obstacles, with zero latency, for same-cycle movement blocking.
- Hit edge detection:
  - Per (i,b), ovl_q registers the gated overlap.
  - new_hit = ovl & ~ovl_q.
  - A bullet resting on an obstacle counts exactly once.
- Hit pulses: hitobj_b is registered, high in cycle t+1 for one cycle when any new_hit(i,b) occurs in cycle t.
- Health update at the same edge:
  - hits += new_hit(i,1) + new_hit(i,2), saturating at MAXHITS.
  - Both bullets striking the same obstacle in one cycle add 2.
- Per-obstacle FSM:
  - ALIVE -> DEAD on the edge where the updated hits reaches MAXHITS. alive drops in the same cycle the final hitobj pulse is high.
  - On entering DEAD: resp_cnt=RESPAWN_FRAMES, ovl_q cleared.
  - DEAD: resp_cnt decrements on each frame_tick.
  - DEAD -> ALIVE on the frame_tick where resp_cnt==1, with hits=0.
  - If RESPAWN_FRAMES=0 the obstacle stays DEAD until reset.
- Respawn with a bullet or tank already overlapping:
  - The bullet registers a new hit on the first cycle after respawn (ovl_q is 0).
  - The tank is blocked immediately.
- Draw path is combinational:
  - The lowest-index alive obstacle containing the pixel wins (x <= DrawX < x+OBST_W, y <= DrawY < y+OBST_H).
  - When draw_hit=0: draw_idx=0, draw_ofs=0, draw_health=0.
- Positions are sampled live each cycle. A position change may create a new hit edge, which is accepted.
- frame_tick and a hit in the same cycle are independent: the tick affects only DEAD obstacles, hits affect only ALIVE ones.

Test Plan:
- Reset, obst 0 at (100,100), p1 bullet at (104,104) held 20 cycles -> hitobj1 high exactly 1 cycle; draw_health at (101,101) = 9.
- Bullet toggled on/off obst 0 ten times (MAXHITS=10) -> 10 hitobj1 pulses; obst_alive[0] falls in the cycle of the 10th pulse; draw_hit=0 at (101,101); Tank1 at (96,96) gives is_obst=0.
- RESPAWN_FRAMES=3 after destruction: 3 frame_ticks -> obst_alive[0]=1 after the 3rd tick, health 10; a bullet left overlapping gives one hitobj1 pulse next cycle.
- p1 and p2 bullets newly overlapping obst 0 in the same cycle -> hitobj1 and hitobj2 pulse together; health drops by 2; at hits=9 both saturate to 10, giving DEAD.
- Obst 0 at (100,100) and obst 1 at (104,104) overlapping, DrawX/DrawY=(106,106) -> draw_idx=0, draw_ofs={6,6}; after obst 0 dies -> draw_idx=1, draw_ofs={2,2}.
- Tank1 at (92,100) -> is_obst=1 (inclusive edge); at (91,100) -> 0; obst at x=1015 with Tank2X=1023 -> is_obst_2=1, no wrap; Reset_h mid-respawn -> all alive, hits 0.
